// File: rtl/imu_spi_pkg.sv
// Shared constants for the IMU SPI register protocol.
// Used by the responder and by the IMU initiator driver.
package imu_spi_pkg;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_COUNT = 128;

  localparam logic [ADDR_W-1:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [ADDR_W-1:0] ADDR_OUT_FIRST = 7'h22;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA,
    WDATA
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin, plus registered edge pulses.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   pin         - asynchronous input pin
//   level       - synchronised level, aligned with the edge pulses
//   rise, fall  - one-clk pulses, 3 clk after the pin edge
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= {2{RESET_VAL}};
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], pin};
      level <= sync[1];
      rise  <= sync[1] & ~level;
      fall  <= ~sync[1] & level;
    end
  end

endmodule

// File: rtl/imu_spi_responder.sv
// Device-side responder for the IMU SPI register protocol (mode 3).
// Decodes a command byte, serves single/burst reads and accepts writes
// into a 128 x 8 register map with WHO_AM_I and sample read-only windows.
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   SPC, CS, SDI       - SPI pins from the initiator (asynchronous)
//   SDO                - SPI data to the initiator
//   sample_data/valid  - 6-axis sample injection into the shadow
//   wr_valid/addr/data - one-clk notification of each committed write
module imu_spi_responder
  import imu_spi_pkg::*;
#(
  parameter int unsigned SAMPLE_BYTES = 12,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6C
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      SPC,
  input  logic                      CS,
  input  logic                      SDI,
  output logic                      SDO,
  input  logic [8*SAMPLE_BYTES-1:0] sample_data,
  input  logic                      sample_valid,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data
);

  localparam int unsigned SAMPLE_W = 8 * SAMPLE_BYTES;

  logic spc_level, spc_rise, spc_fall;
  logic cs_level, cs_rise, cs_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic sync_unused;

  spi_state_e state, state_next;

  logic                armed;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   rx_shift;
  logic [DATA_W-1:0]   tx_shift;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   regs [REG_COUNT];
  logic [SAMPLE_W-1:0] shadow;
  logic [SAMPLE_W-1:0] pend_data;
  logic                pending;

  logic [DATA_W-1:0]   rx_byte_c;
  logic                byte_done_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic [DATA_W-1:0]   rd_data_c;

  // SPC idles high; CS resets low so "CS high" is only seen from the real pin.
  spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_spc (
    .clk(clk), .reset(reset), .pin(SPC), .level(spc_level), .rise(spc_rise), .fall(spc_fall)
  );
  spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset(reset), .pin(CS), .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .pin(SDI), .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );

  assign sync_unused = &{1'b0, spc_level, cs_rise, cs_fall, sdi_rise, sdi_fall};

  function automatic logic is_read_only(input logic [ADDR_W-1:0] a);
    logic ro;
    ro = (a == ADDR_WHO_AM_I);
    for (int unsigned k = 0; k < SAMPLE_BYTES; k++) begin
      if (a == ADDR_W'(32'(ADDR_OUT_FIRST) + k)) ro = 1'b1;
    end
    return ro;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state; CS high aborts from anywhere, including on an 8th edge
  always_comb begin
    state_next  = state;
    rx_byte_c   = {rx_shift[6:0], sdi_level};
    byte_done_c = spc_rise && (bit_cnt == 3'd7);
    case (state)
      IDLE:  if (armed && !cs_level) state_next = CMD;
      CMD: begin
        if (cs_level)         state_next = IDLE;
        else if (byte_done_c) state_next = rx_byte_c[7] ? RDATA : WDATA;
      end
      RDATA: if (cs_level) state_next = IDLE;
      WDATA: if (cs_level) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read mux: the command address on the command byte, else the next burst address
  always_comb begin
    rd_addr_c = (state == CMD) ? rx_byte_c[6:0] : addr + 7'd1;
    rd_data_c = regs[rd_addr_c];
    if (rd_addr_c == ADDR_WHO_AM_I) rd_data_c = WHO_AM_I_VAL;
    for (int unsigned k = 0; k < SAMPLE_BYTES; k++) begin
      if (rd_addr_c == ADDR_W'(32'(ADDR_OUT_FIRST) + k)) rd_data_c = shadow[8*k +: 8];
    end
  end

  // Shift, address and register-file datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      armed    <= 1'b0;
      bit_cnt  <= 3'd0;
      rx_shift <= '0;
      tx_shift <= 8'hFF;
      addr     <= '0;
      SDO      <= 1'b1;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      armed    <= armed | cs_level;
      if (state == IDLE || cs_level) begin
        bit_cnt <= 3'd0;
        SDO     <= 1'b1;
      end else begin
        if (spc_rise) begin
          rx_shift <= rx_byte_c;
          bit_cnt  <= bit_cnt + 3'd1;
          if (byte_done_c) begin
            case (state)
              CMD: begin
                addr     <= rx_byte_c[6:0];
                tx_shift <= rd_data_c;
              end
              RDATA: begin
                addr     <= rd_addr_c;
                tx_shift <= rd_data_c;
              end
              WDATA: begin
                if (!is_read_only(addr)) begin
                  regs[addr] <= rx_byte_c;
                  wr_valid   <= 1'b1;
                  wr_addr    <= addr;
                  wr_data    <= rx_byte_c;
                end
                addr <= addr + 7'd1;
              end
              default: ;
            endcase
          end
        end
        if (spc_fall && state == RDATA) begin
          SDO      <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
      end
    end
  end

  // Sample shadow; strobes during a frame are held until CS returns high
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      pend_data <= '0;
      pending   <= 1'b0;
    end else if (sample_valid) begin
      if (cs_level) begin
        shadow  <= sample_data;
        pending <= 1'b0;
      end else begin
        pend_data <= sample_data;
        pending   <= 1'b1;
      end
    end else if (pending && cs_level) begin
      shadow  <= pend_data;
      pending <= 1'b0;
    end
  end

endmodule
